// File: rtl/lock_pkg.sv
// Shared types and helpers for the password lock: state encoding, symbol width,
// and the one-hot key to symbol decoder.
package lock_pkg;

  localparam int unsigned SYM_W = 2;

  typedef enum logic [2:0] {
    StLocked     = 3'd0,
    StOpen       = 3'd1,
    StSetNew     = 3'd2,
    StSetConfirm = 3'd3,
    StError      = 3'd4
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [SYM_W-1:0] sym;
  } key_sym_t;

  // Zero or multi-hot vectors are not a key press.
  function automatic key_sym_t decode_key(input logic [3:0] keys);
    key_sym_t r;
    r.valid = 1'b1;
    r.sym   = '0;
    unique case (keys)
      4'b0001: r.sym = 2'd0;
      4'b0010: r.sym = 2'd1;
      4'b0100: r.sym = 2'd2;
      4'b1000: r.sym = 2'd3;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/error_timer.sv
// Down-counter that holds the lock in ERROR: load starts it, done marks the
// final cycle of the hold window.
module error_timer #(
  parameter int unsigned CYCLES = 4,
  localparam int unsigned W = $clog2(CYCLES)
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic done
);

  logic [W-1:0] count_q;
  logic         active_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      count_q  <= W'(CYCLES - 1);
      active_q <= 1'b1;
    end else if (active_q) begin
      if (count_q == '0) begin
        active_q <= 1'b0;
      end else begin
        count_q <= count_q - W'(1);
      end
    end
  end

  assign done = active_q && (count_q == '0);

endmodule

// File: rtl/password_lock_fsm.sv
// Password lock: collects key presses, unlocks on a matching entry, and lets the
// user change the password (enter + confirm) while unlocked.
module password_lock_fsm
  import lock_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter logic [DIGITS*SYM_W-1:0] DEFAULT_PW = 8'hE4,
  parameter int unsigned ERROR_CYCLES = 50000000,
  localparam int unsigned CNT_W = $clog2(DIGITS + 1),
  localparam int unsigned PW_W = DIGITS * SYM_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       key_pressed,
  output logic             locked,
  output logic             unlocked,
  output logic             error,
  output logic [CNT_W-1:0] digit_count,
  output logic [2:0]       state_code
);

  state_e           state_q, state_d;
  state_e           ret_q, ret_d;
  logic [CNT_W-1:0] count_q;
  logic [PW_W-1:0]  entry_buf_q, new_buf_q, stored_pw_q;
  logic [PW_W-1:0]  entry_full;
  logic             locked_q, unlocked_q, error_q;
  logic             timer_load, timer_done;
  key_sym_t         key;
  logic             last;

  assign key  = decode_key(key_pressed);
  assign last = (count_q == CNT_W'(DIGITS - 1));

  // Buffer with the incoming symbol merged in, so the final digit compares same-cycle.
  always_comb begin
    entry_full = entry_buf_q;
    entry_full[count_q*SYM_W +: SYM_W] = key.sym;
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    case (state_q)
      StLocked: begin
        if (key.valid && last) begin
          if (entry_full == stored_pw_q) begin
            state_d = StOpen;
          end else begin
            state_d = StError;
            ret_d   = StLocked;
          end
        end
      end
      StOpen: begin
        if (key.valid) state_d = last ? StSetConfirm : StSetNew;
      end
      StSetNew: begin
        if (key.valid && last) state_d = StSetConfirm;
      end
      StSetConfirm: begin
        if (key.valid && last) begin
          if (entry_full == new_buf_q) begin
            state_d = StLocked;
          end else begin
            state_d = StError;
            ret_d   = StOpen;
          end
        end
      end
      StError: begin
        if (timer_done) state_d = ret_q;
      end
      default: state_d = StLocked;
    endcase
  end

  assign timer_load = (state_d == StError) && (state_q != StError);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StLocked;
      ret_q       <= StLocked;
      count_q     <= '0;
      entry_buf_q <= '0;
      new_buf_q   <= '0;
      stored_pw_q <= DEFAULT_PW;
      locked_q    <= 1'b1;
      unlocked_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      locked_q   <= (state_d == StLocked) || (state_d == StError && ret_d == StLocked);
      unlocked_q <= (state_d inside {StOpen, StSetNew, StSetConfirm}) ||
                    (state_d == StError && ret_d == StOpen);
      error_q    <= (state_d == StError);

      if (state_d != state_q) begin
        // OPEN -> SET_NEW keeps the triggering press as digit 0 of the new password.
        if (state_q == StOpen && state_d == StSetNew) begin
          count_q     <= CNT_W'(1);
          entry_buf_q <= entry_full;
        end else begin
          count_q     <= '0;
          entry_buf_q <= '0;
        end
      end else if (key.valid && state_q != StError) begin
        count_q     <= count_q + CNT_W'(1);
        entry_buf_q <= entry_full;
      end

      if ((state_q == StOpen || state_q == StSetNew) && key.valid && last) begin
        new_buf_q <= entry_full;
      end
      if (state_q == StSetConfirm && state_d == StLocked) begin
        stored_pw_q <= new_buf_q;
      end
    end
  end

  error_timer #(
    .CYCLES(ERROR_CYCLES)
  ) u_error_timer (
    .clock(clock),
    .reset(reset),
    .load (timer_load),
    .done (timer_done)
  );

  assign locked      = locked_q;
  assign unlocked    = unlocked_q;
  assign error       = error_q;
  assign digit_count = count_q;
  assign state_code  = state_q;

endmodule

// File: tb/tb_password_lock_fsm.sv
// Directed bench for password_lock_fsm: unlock, error hold, password change,
// invalid key vectors and reset mid-entry.
module tb_password_lock_fsm;

  logic       clock;
  logic       reset;
  logic [3:0] key_pressed;
  logic       locked, unlocked, error;
  logic [2:0] digit_count;
  logic [2:0] state_code;

  int n_cmp = 0;
  int n_err = 0;

  password_lock_fsm #(
    .DIGITS      (4),
    .DEFAULT_PW  (8'hE4),
    .ERROR_CYCLES(4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .key_pressed(key_pressed),
    .locked     (locked),
    .unlocked   (unlocked),
    .error      (error),
    .digit_count(digit_count),
    .state_code (state_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Checks all status outputs at once.
  task automatic expect_out(input string tag, input logic lk, input logic ul, input logic er,
                            input logic [2:0] cnt, input logic [2:0] code);
    check({tag, ".locked"}, 32'(locked), 32'(lk));
    check({tag, ".unlocked"}, 32'(unlocked), 32'(ul));
    check({tag, ".error"}, 32'(error), 32'(er));
    check({tag, ".count"}, 32'(digit_count), 32'(cnt));
    check({tag, ".state"}, 32'(state_code), 32'(code));
  endtask

  // One-cycle pulse; returns 1ns after the sampling edge.
  task automatic press(input logic [3:0] k);
    key_pressed = k;
    @(posedge clock);
    #1;
    key_pressed = 4'b0000;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d);
    press(a);
    press(b);
    press(c);
    press(d);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    key_pressed = 4'b0000;
    repeat (2) @(posedge clock);
    #1;
    expect_out("reset", 1, 0, 0, 0, 3'd0);
    reset = 1'b0;

    // 1: default password unlocks on the edge sampling the 4th press
    press(4'd1); press(4'd2); press(4'd4);
    expect_out("s1_partial", 1, 0, 0, 3, 3'd0);
    press(4'd8);
    expect_out("s1_open", 0, 1, 0, 0, 3'd1);

    // 2: wrong entry holds error exactly 4 cycles; presses in error ignored
    do_reset();
    enter4(4'd1, 4'd2, 4'd4, 4'd4);
    expect_out("s2_err0", 1, 0, 1, 0, 3'd4);
    press(4'd1);
    expect_out("s2_err1", 1, 0, 1, 0, 3'd4);
    press(4'd2);
    step();
    expect_out("s2_err3", 1, 0, 1, 0, 3'd4);
    step();
    expect_out("s2_back", 1, 0, 0, 0, 3'd0);
    enter4(4'd1, 4'd2, 4'd4, 4'd8);
    expect_out("s2_open", 0, 1, 0, 0, 3'd1);

    // 3: change password to 3,3,0,0
    press(4'd8);
    expect_out("s3_setnew", 0, 1, 0, 1, 3'd2);
    press(4'd8); press(4'd1); press(4'd1);
    expect_out("s3_confirm", 0, 1, 0, 0, 3'd3);
    enter4(4'd8, 4'd8, 4'd1, 4'd1);
    expect_out("s3_relock", 1, 0, 0, 0, 3'd0);
    enter4(4'd1, 4'd2, 4'd4, 4'd8);
    expect_out("s3_oldpw", 1, 0, 1, 0, 3'd4);
    repeat (4) step();
    expect_out("s3_back", 1, 0, 0, 0, 3'd0);
    enter4(4'd8, 4'd8, 4'd1, 4'd1);
    expect_out("s3_newpw", 0, 1, 0, 0, 3'd1);

    // 4: confirm mismatch -> error back to OPEN, stored password unchanged
    do_reset();
    enter4(4'd1, 4'd2, 4'd4, 4'd8);
    enter4(4'd8, 4'd8, 4'd1, 4'd1);
    enter4(4'd8, 4'd8, 4'd1, 4'd2);
    expect_out("s4_err", 0, 1, 1, 0, 3'd4);
    repeat (3) step();
    expect_out("s4_err3", 0, 1, 1, 0, 3'd4);
    step();
    expect_out("s4_open", 0, 1, 0, 0, 3'd1);
    enter4(4'd1, 4'd2, 4'd4, 4'd8);
    enter4(4'd1, 4'd2, 4'd4, 4'd8);
    expect_out("s4_relock", 1, 0, 0, 0, 3'd0);
    enter4(4'd8, 4'd8, 4'd1, 4'd1);
    expect_out("s4_rejected", 1, 0, 1, 0, 3'd4);
    repeat (4) step();
    enter4(4'd1, 4'd2, 4'd4, 4'd8);
    expect_out("s4_unlock", 0, 1, 0, 0, 3'd1);

    // 5: zero and multi-hot vectors are no-ops
    do_reset();
    press(4'd1);
    press(4'b0011);
    expect_out("s5_multi", 1, 0, 0, 1, 3'd0);
    press(4'd2);
    press(4'b0000);
    press(4'd4);
    press(4'b1100);
    expect_out("s5_three", 1, 0, 0, 3, 3'd0);
    press(4'd8);
    expect_out("s5_open", 0, 1, 0, 0, 3'd1);

    // 6: reset mid-confirm
    enter4(4'd8, 4'd8, 4'd1, 4'd1);
    press(4'd8); press(4'd8);
    expect_out("s6_mid", 0, 1, 0, 2, 3'd3);
    reset = 1'b1;
    #1;
    expect_out("s6_async", 1, 0, 0, 0, 3'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    enter4(4'd1, 4'd2, 4'd4, 4'd8);
    expect_out("s6_default", 0, 1, 0, 0, 3'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
